timekeeper_core: RTL and testbench



---
 rtl/timekeeper_pkg.sv | 39 +++
 rtl/timekeeper_mod_counter.sv | 45 ++++
 rtl/timekeeper_core.sv | 166 ++++++++++++++++
 tb/tb_timekeeper_core.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/timekeeper_pkg.sv
// timekeeper_pkg: shared limits, field widths, the hh:mm:ss struct and
// small helpers used by the timekeeper core.
package timekeeper_pkg;

  localparam int HR_MAX  = 23;
  localparam int MIN_MAX = 59;
  localparam int SEC_MAX = 59;

  localparam int HR_W  = 5;
  localparam int MIN_W = 6;
  localparam int SEC_W = 6;
  localparam int HMS_W = HR_W + MIN_W + SEC_W;

  // Whole-second part of the time; the sub-second field is sized per instance.
  typedef struct packed {
    logic [HR_W-1:0]  hr;
    logic [MIN_W-1:0] min;
    logic [SEC_W-1:0] sec;
  } hms_t;

  // True when every field of a requested load is a legal 24-hour value.
  function automatic logic hms_in_range(input hms_t t);
    return (t.hr  <= HR_W'(HR_MAX)) &&
           (t.min <= MIN_W'(MIN_MAX)) &&
           (t.sec <= SEC_W'(SEC_MAX));
  endfunction

  // Hour as shown to the user: unchanged in 24-hour mode, 1..12 in 12-hour mode.
  function automatic logic [HR_W-1:0] disp_hour(input logic [HR_W-1:0] hr,
                                                input logic mode12);
    logic [HR_W-1:0] h12;
    h12 = (hr >= HR_W'(12)) ? (hr - HR_W'(12)) : hr;
    if (!mode12) begin
      return hr;
    end
    return (h12 == '0) ? HR_W'(12) : h12;
  endfunction

endpackage

// File: rtl/timekeeper_mod_counter.sv
// mod_counter: one modulo-(MAX+1) time field with synchronous load and a
// wrap-carry that fires on the increment that takes the field from MAX to 0.
module mod_counter #(
  parameter int MAX = 59,
  parameter int W   = 6
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         inc_i,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  output logic [W-1:0] cnt_o,
  output logic         carry_o
);

  localparam logic [W-1:0] MAX_V = W'(MAX);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;
  logic         at_max;

  assign at_max  = (cnt_q == MAX_V);
  assign carry_o = inc_i & ~load_i & at_max;
  assign cnt_o   = cnt_q;

  // Next count: a load overrides an increment; increments wrap at MAX.
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (inc_i) begin
      cnt_d = at_max ? '0 : (cnt_q + W'(1));
    end
  end

  // Field register, cleared asynchronously.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/timekeeper_core.sv
// timekeeper_core: 24-hour hh:mm:ss.subsec counter with a validated load
// port and a registered 12/24-hour display.
// Optional alarm: define TIMEKEEPER_ALARM_EN to add the alarm ports/logic;
// otherwise alarm_ring is tied low.
module timekeeper_core
  import timekeeper_pkg::*;
#(
  parameter int SUBSEC_MAX = 999,
  parameter int SUBSEC_W   = 10,
  parameter int MODE12_RST = 0
) (
  input  logic                        kh_clk,
  input  logic                        reset_n,
  input  logic                        tick_en,
  input  logic                        mode12,
  input  logic                        set_valid,
  input  logic [HR_W-1:0]             set_hr,
  input  logic [MIN_W-1:0]            set_min,
  input  logic [SEC_W-1:0]            set_sec,
`ifdef TIMEKEEPER_ALARM_EN
  input  logic [HR_W-1:0]             alarm_hr,
  input  logic [MIN_W-1:0]            alarm_min,
  input  logic                        alarm_arm,
  input  logic                        alarm_ack,
`endif
  output logic                        set_ready,
  output logic                        set_err,
  output logic [HMS_W+SUBSEC_W-1:0]   disp_time,
  output logic                        pm,
  output logic                        alarm_ring
);

  localparam int DISP_W = HMS_W + SUBSEC_W;

  if (SUBSEC_MAX >= (2 ** SUBSEC_W)) begin : g_bad_subsec
    $error("SUBSEC_MAX does not fit in SUBSEC_W bits");
  end

  hms_t                set_t;
  logic                set_ok;
  logic                load;
  logic                tick;

  logic [SUBSEC_W-1:0] sub_q;
  logic [SEC_W-1:0]    sec_q;
  logic [MIN_W-1:0]    min_q;
  logic [HR_W-1:0]     hr_q;
  logic                sub_carry;
  logic                sec_carry;
  logic                min_carry;
  logic                hr_carry_unused;

  logic                mode_q;
  logic                err_q;
  logic                err_d;
  logic [DISP_W-1:0]   disp_q;
  logic [DISP_W-1:0]   disp_d;
  logic                pm_q;
  logic                pm_d;

  // Loads are always accepted; an out-of-range request freezes the counters
  // (including any coincident tick) and only raises set_err.
  assign set_ready = reset_n;
  assign set_t     = {set_hr, set_min, set_sec};
  assign set_ok    = hms_in_range(set_t);
  assign load      = set_valid & set_ok;
  assign tick      = tick_en & ~set_valid;
  assign err_d     = set_valid & ~set_ok;

  mod_counter #(.MAX(SUBSEC_MAX), .W(SUBSEC_W)) u_subsec (
    .clk_i      (kh_clk),
    .rst_ni     (reset_n),
    .inc_i      (tick),
    .load_i     (load),
    .load_val_i ('0),
    .cnt_o      (sub_q),
    .carry_o    (sub_carry)
  );

  mod_counter #(.MAX(SEC_MAX), .W(SEC_W)) u_sec (
    .clk_i      (kh_clk),
    .rst_ni     (reset_n),
    .inc_i      (sub_carry),
    .load_i     (load),
    .load_val_i (set_sec),
    .cnt_o      (sec_q),
    .carry_o    (sec_carry)
  );

  mod_counter #(.MAX(MIN_MAX), .W(MIN_W)) u_min (
    .clk_i      (kh_clk),
    .rst_ni     (reset_n),
    .inc_i      (sec_carry),
    .load_i     (load),
    .load_val_i (set_min),
    .cnt_o      (min_q),
    .carry_o    (min_carry)
  );

  mod_counter #(.MAX(HR_MAX), .W(HR_W)) u_hr (
    .clk_i      (kh_clk),
    .rst_ni     (reset_n),
    .inc_i      (min_carry),
    .load_i     (load),
    .load_val_i (set_hr),
    .cnt_o      (hr_q),
    .carry_o    (hr_carry_unused)
  );

  // Display image of the current counters in the registered display mode.
  always_comb begin
    disp_d = {disp_hour(hr_q, mode_q), min_q, sec_q, sub_q};
    pm_d   = (hr_q >= HR_W'(12));
  end

  // Display mode, error pulse and display registers; one-cycle display latency.
  always_ff @(posedge kh_clk or negedge reset_n) begin
    if (!reset_n) begin
      mode_q <= (MODE12_RST != 0);
      err_q  <= 1'b0;
      disp_q <= '0;
      pm_q   <= 1'b0;
    end else begin
      mode_q <= mode12;
      err_q  <= err_d;
      disp_q <= disp_d;
      pm_q   <= pm_d;
    end
  end

  assign set_err   = err_q;
  assign disp_time = disp_q;
  assign pm        = pm_q;

`ifdef TIMEKEEPER_ALARM_EN
  logic upd_q;
  logic ring_q;
  logic ring_d;
  logic match;

  // A match only counts on the cycle right after a tick or load moved the
  // counters, so a frozen clock sitting on the alarm time cannot re-trigger.
  always_comb begin
    match  = upd_q & alarm_arm &
             (hr_q == alarm_hr) & (min_q == alarm_min) &
             (sec_q == '0) & (sub_q == '0);
    ring_d = match | (ring_q & alarm_arm & ~alarm_ack);
  end

  // Counter-update marker and latched alarm output.
  always_ff @(posedge kh_clk or negedge reset_n) begin
    if (!reset_n) begin
      upd_q  <= 1'b0;
      ring_q <= 1'b0;
    end else begin
      upd_q  <= load | tick;
      ring_q <= ring_d;
    end
  end

  assign alarm_ring = ring_q;
`else
  assign alarm_ring = 1'b0;
`endif

endmodule

// File: tb/tb_timekeeper_core.sv
// tb_timekeeper_core: table-driven vectors plus hand-written corner sequences;
// a total-count reference model feeds a per-cycle scoreboard queue.
module tb_timekeeper_core;

  localparam int SM  = 999;
  localparam int SW  = 10;
  localparam int DW  = 17 + SW;
  localparam int TPS = SM + 1;
  localparam int TOT = 86400 * TPS;

  logic          kh_clk    = 1'b0;
  logic          reset_n   = 1'b0;
  logic          tick_en   = 1'b0;
  logic          mode12    = 1'b0;
  logic          set_valid = 1'b0;
  logic [4:0]    set_hr    = '0;
  logic [5:0]    set_min   = '0;
  logic [5:0]    set_sec   = '0;
  logic          set_ready;
  logic          set_err;
  logic [DW-1:0] disp_time;
  logic          pm;
  logic          alarm_ring;
`ifdef TIMEKEEPER_ALARM_EN
  logic [4:0]    alarm_hr  = '0;
  logic [5:0]    alarm_min = '0;
  logic          alarm_arm = 1'b0;
  logic          alarm_ack = 1'b0;
`endif

  always #5 kh_clk = ~kh_clk;

  timekeeper_core #(.SUBSEC_MAX(SM), .SUBSEC_W(SW), .MODE12_RST(0)) dut (
    .kh_clk     (kh_clk),
    .reset_n    (reset_n),
    .tick_en    (tick_en),
    .mode12     (mode12),
    .set_valid  (set_valid),
    .set_hr     (set_hr),
    .set_min    (set_min),
    .set_sec    (set_sec),
`ifdef TIMEKEEPER_ALARM_EN
    .alarm_hr   (alarm_hr),
    .alarm_min  (alarm_min),
    .alarm_arm  (alarm_arm),
    .alarm_ack  (alarm_ack),
`endif
    .set_ready  (set_ready),
    .set_err    (set_err),
    .disp_time  (disp_time),
    .pm         (pm),
    .alarm_ring (alarm_ring)
  );

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
    end
  endtask

  // Reference model: time as a single count of sub-second ticks since midnight.
  int m_tot  = 0;
  bit m_mode = 1'b0;

  function automatic logic [DW-1:0] mdisp(input int tot, input bit md);
    int sub, t, s, mi, h, dh;
    sub = tot % TPS;
    t   = tot / TPS;
    s   = t % 60;
    mi  = (t / 60) % 60;
    h   = t / 3600;
    dh  = md ? (((h % 12) == 0) ? 12 : (h % 12)) : h;
    return {5'(dh), 6'(mi), 6'(s), SW'(sub)};
  endfunction

  typedef struct {
    logic [DW-1:0] disp;
    logic          pm;
    logic          err;
  } exp_t;

  exp_t sb[$];

  // One clock: drive inputs, queue the expected post-edge outputs, update the
  // model on the edge, then pop and compare just after the edge.
  task automatic cyc(input bit tk, input bit sv, input int h, input int mi,
                     input int s, input bit md);
    exp_t e;
    exp_t g;
    bit   ok;
    tick_en   = tk;
    set_valid = sv;
    set_hr    = 5'(h);
    set_min   = 6'(mi);
    set_sec   = 6'(s);
    mode12    = md;
    ok        = (h <= 23) && (mi <= 59) && (s <= 59);
    e.disp    = mdisp(m_tot, m_mode);
    e.pm      = (m_tot / (TPS * 3600)) >= 12;
    e.err     = sv && !ok;
    sb.push_back(e);
    @(posedge kh_clk);
    if (sv) begin
      if (ok) m_tot = ((h * 60 + mi) * 60 + s) * TPS;
    end else if (tk) begin
      m_tot = (m_tot + 1) % TOT;
    end
    m_mode = md;
    #1;
    if (sb.size() == 0) begin
      n_chk++;
      n_err++;
      $display("FAIL scoreboard_empty actual=0 expected=1");
    end else begin
      g = sb.pop_front();
      chk("sb_disp", disp_time, g.disp);
      chk("sb_pm", pm, g.pm);
      chk("sb_set_err", set_err, g.err);
    end
  endtask

  typedef struct {
    bit         tk;
    bit         sv;
    bit         md;
    int         rep;
    int         h;
    int         mi;
    int         s;
    bit         xerr;
    logic [4:0] xh;
    logic [5:0] xm;
    logic [5:0] xs;
    logic [9:0] xsub;
    bit         xpm;
  } vec_t;

  vec_t vt[17];

  initial begin
    vt[0]  = '{0, 1, 0, 1,   23, 59, 59, 0, 23, 59, 59, 0, 1};
    vt[1]  = '{1, 0, 0, TPS,  0,  0,  0, 0,  0,  0,  0, 0, 0};
    vt[2]  = '{0, 0, 1, 1,    0,  0,  0, 0, 12,  0,  0, 0, 0};
    vt[3]  = '{0, 1, 1, 1,   13,  5,  0, 0,  1,  5,  0, 0, 1};
    vt[4]  = '{0, 0, 0, 1,    0,  0,  0, 0, 13,  5,  0, 0, 1};
    vt[5]  = '{0, 1, 0, 1,   24,  0,  0, 1, 13,  5,  0, 0, 1};
    vt[6]  = '{1, 1, 0, 1,   12,  0, 60, 1, 13,  5,  0, 0, 1};
    vt[7]  = '{1, 0, 0, 5,    0,  0,  0, 0, 13,  5,  0, 5, 1};
    vt[8]  = '{1, 1, 0, 1,   10, 20, 30, 0, 10, 20, 30, 0, 0};
    vt[9]  = '{1, 1, 0, 3,    5,  6,  7, 0,  5,  6,  7, 0, 0};
    vt[10] = '{0, 1, 1, 1,    0,  0,  0, 0, 12,  0,  0, 0, 0};
    vt[11] = '{0, 1, 1, 1,   11, 59, 59, 0, 11, 59, 59, 0, 0};
    vt[12] = '{1, 0, 1, TPS,  0,  0,  0, 0, 12,  0,  0, 0, 1};
    vt[13] = '{0, 1, 0, 1,    0, 59, 59, 0,  0, 59, 59, 0, 0};
    vt[14] = '{1, 0, 0, TPS,  0,  0,  0, 0,  1,  0,  0, 0, 0};
    vt[15] = '{0, 1, 1, 1,   23,  0,  0, 0, 11,  0,  0, 0, 1};
    vt[16] = '{0, 1, 1, 1,   12, 60,  0, 1, 11,  0,  0, 0, 1};

    // Reset state.
    repeat (2) @(posedge kh_clk);
    #1;
    chk("rst_disp", disp_time, 0);
    chk("rst_pm", pm, 0);
    chk("rst_set_err", set_err, 0);
    chk("rst_alarm_ring", alarm_ring, 0);
    @(negedge kh_clk);
    reset_n = 1'b1;
    #1;
    chk("set_ready", set_ready, 1);

    // 1000 ticks from reset give exactly one second.
    repeat (TPS) cyc(1, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0);
    chk("one_second", disp_time, {5'd0, 6'd0, 6'd1, 10'd0});

    // Table-driven vectors.
    for (int i = 0; i < 17; i++) begin
      for (int r = 0; r < vt[i].rep; r++) begin
        cyc(vt[i].tk, vt[i].sv, vt[i].h, vt[i].mi, vt[i].s, vt[i].md);
      end
      chk($sformatf("vec%0d_set_err", i), set_err, vt[i].xerr);
      cyc(0, 0, 0, 0, 0, vt[i].md);
      chk($sformatf("vec%0d_disp", i), disp_time,
          {vt[i].xh, vt[i].xm, vt[i].xs, vt[i].xsub});
      chk($sformatf("vec%0d_pm", i), pm, vt[i].xpm);
    end

`ifdef TIMEKEEPER_ALARM_EN
    // Alarm at 07:30 reached by ticking over from 07:29:59.
    alarm_hr  = 5'd7;
    alarm_min = 6'd30;
    alarm_arm = 1'b1;
    cyc(0, 1, 7, 29, 59, 0);
    repeat (TPS) cyc(1, 0, 0, 0, 0, 0);
    chk("alarm_before", alarm_ring, 0);
    cyc(0, 0, 0, 0, 0, 0);
    chk("alarm_rise", alarm_ring, 1);
    repeat (3) cyc(1, 0, 0, 0, 0, 0);
    chk("alarm_hold", alarm_ring, 1);
    alarm_ack = 1'b1;
    cyc(0, 0, 0, 0, 0, 0);
    alarm_ack = 1'b0;
    chk("alarm_ack", alarm_ring, 0);
    alarm_arm = 1'b0;
`else
    chk("alarm_tied_low", alarm_ring, 0);
`endif

    // Asynchronous reset mid-run, just after a bad load raised set_err.
    repeat (7) cyc(1, 0, 0, 0, 0, 1);
    cyc(0, 1, 13, 61, 0, 1);
    chk("pre_rst_set_err", set_err, 1);
    #2;
    reset_n = 1'b0;
    #1;
    chk("async_rst_disp", disp_time, 0);
    chk("async_rst_pm", pm, 0);
    chk("async_rst_set_err", set_err, 0);
    chk("async_rst_alarm_ring", alarm_ring, 0);
    m_tot  = 0;
    m_mode = 1'b0;
    @(negedge kh_clk);
    reset_n = 1'b1;
    cyc(1, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0);
    chk("resume", disp_time, {5'd0, 6'd0, 6'd0, 10'd1});

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

  // Watchdog so the run always terminates.
  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
